// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC and picks ADVANCE/HOLD/BUBBLE for the decode pipe register
module fetch_sequencer #(
    parameter int                     PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC     = '0,
    parameter int                     WAIT_TIMEOUT = 64,
    parameter int                     CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_is_branch,
    input  logic                 predict_taken,
    input  logic                 btb_hit,
    input  logic [PC_WIDTH-1:0]  btb_target,
    input  logic                 data_hazard,
    input  logic                 structure_stall,
    input  logic                 mispredict,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    input  logic                 resolve_valid,
    input  logic [PC_WIDTH-1:0]  resolve_pc,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [1:0]           pipe_op,
    output logic                 out_pred_taken,
    output logic                 out_next_pc_predicted,
    output logic [PC_WIDTH-1:0]  out_predicted_next_pc,
    output logic                 state,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic                 wait_timeout
);
    localparam int WCW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [1:0] OP_ADVANCE = 2'd0;
    localparam logic [1:0] OP_HOLD    = 2'd1;
    localparam logic [1:0] OP_BUBBLE  = 2'd2;
    localparam logic [PC_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_WIDTH-1:2], 2'b00};

    typedef enum logic {RUN = 1'b0, WAIT_TARGET = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic                 wto_q, wto_d;

    assign pc           = pc_q;
    assign state        = state_q;
    assign stall_cycles = stall_q;
    assign wait_timeout = wto_q;

    // Priority arbitration: redirect > stall > wait-for-target > BTB jump > sequential
    always_comb begin
        pc_d                  = pc_q;
        state_d               = state_q;
        stall_d               = stall_q;
        wcnt_d                = wcnt_q;
        wto_d                 = wto_q;
        pipe_op               = OP_ADVANCE;
        out_pred_taken        = 1'b0;
        out_next_pc_predicted = 1'b0;
        out_predicted_next_pc = '0;
        if (rst) begin
            pipe_op = OP_BUBBLE;
        end else if (mispredict) begin
            pipe_op = OP_BUBBLE;
            pc_d    = {redirect_pc[PC_WIDTH-1:2], 2'b00};
            state_d = RUN;
            wcnt_d  = '0;
        end else if (data_hazard || structure_stall) begin
            pipe_op = OP_HOLD;
            stall_d = &stall_q ? stall_q : stall_q + CNT_WIDTH'(1);
        end else if (state_q == WAIT_TARGET) begin
            pipe_op = OP_BUBBLE;
            if (resolve_valid) begin
                pc_d    = {resolve_pc[PC_WIDTH-1:2], 2'b00};
                state_d = RUN;
                wcnt_d  = '0;
            end else begin
                wcnt_d = (wcnt_q == WCW'(WAIT_TIMEOUT)) ? wcnt_q : wcnt_q + WCW'(1);
                wto_d  = wto_q | (wcnt_d == WCW'(WAIT_TIMEOUT));
            end
        end else if (inst_is_branch && predict_taken && btb_hit) begin
            out_pred_taken        = 1'b1;
            out_next_pc_predicted = 1'b1;
            out_predicted_next_pc = btb_target;
            pc_d                  = {btb_target[PC_WIDTH-1:2], 2'b00};
        end else if (inst_is_branch && predict_taken) begin
            out_pred_taken = 1'b1;
            state_d        = WAIT_TARGET;
        end else begin
            out_pred_taken = predict_taken & inst_is_branch;
            pc_d           = pc_q + PC_WIDTH'(4);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC_ALIGNED;
            state_q <= RUN;
            stall_q <= '0;
            wcnt_q  <= '0;
            wto_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            stall_q <= stall_d;
            wcnt_q  <= wcnt_d;
            wto_q   <= wto_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenario bench for fetch_sequencer
module tb_fetch_sequencer;
    logic        clk, rst;
    logic        inst_is_branch, predict_taken, btb_hit;
    logic [31:0] btb_target;
    logic        data_hazard, structure_stall, mispredict;
    logic [31:0] redirect_pc;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic [31:0] pc;
    logic [1:0]  pipe_op;
    logic        out_pred_taken, out_next_pc_predicted;
    logic [31:0] out_predicted_next_pc;
    logic        state;
    logic [15:0] stall_cycles;
    logic        wait_timeout;
    int errors = 0;
    int checks = 0;

    fetch_sequencer dut (
        .clk(clk), .rst(rst),
        .inst_is_branch(inst_is_branch), .predict_taken(predict_taken),
        .btb_hit(btb_hit), .btb_target(btb_target),
        .data_hazard(data_hazard), .structure_stall(structure_stall),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .pc(pc), .pipe_op(pipe_op),
        .out_pred_taken(out_pred_taken), .out_next_pc_predicted(out_next_pc_predicted),
        .out_predicted_next_pc(out_predicted_next_pc),
        .state(state), .stall_cycles(stall_cycles), .wait_timeout(wait_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        inst_is_branch = 0; predict_taken = 0; btb_hit = 0; btb_target = 0;
        data_hazard = 0; structure_stall = 0; mispredict = 0; redirect_pc = 0;
        resolve_valid = 0; resolve_pc = 0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        idle();
        mispredict = 1; redirect_pc = target;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        checks++; if (pipe_op !== 2'd2) begin errors++; $display("FAIL reset_pipe_op: got %0d expected 2", pipe_op); end
        checks++; if ({out_pred_taken, out_next_pc_predicted, out_predicted_next_pc} !== 34'd0) begin errors++; $display("FAIL reset_pred_outs: got %b %b %h expected all zero", out_pred_taken, out_next_pc_predicted, out_predicted_next_pc); end
        tick();
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc); end
        checks++; if ({state, wait_timeout} !== 2'b00) begin errors++; $display("FAIL reset_state_wto: got %b%b expected 00", state, wait_timeout); end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
        rst = 0;
        #1;
    endtask

    task automatic test_straight_line();
        idle();
        for (int i = 0; i < 4; i++) begin
            checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL straight_pc%0d: got %h expected %h", i, pc, 4 * i); end
            checks++; if (pipe_op !== 2'd0) begin errors++; $display("FAIL straight_op%0d: got %0d expected 0", i, pipe_op); end
            tick();
        end
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL straight_stall: got %0d expected 0", stall_cycles); end
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL straight_end_pc: got %h expected 10", pc); end
    endtask

    task automatic test_btb_hit();
        idle();
        inst_is_branch = 1; predict_taken = 1; btb_hit = 1; btb_target = 32'h40;
        #1;
        checks++; if (pipe_op !== 2'd0) begin errors++; $display("FAIL btb_op: got %0d expected 0", pipe_op); end
        checks++; if ({out_pred_taken, out_next_pc_predicted} !== 2'b11) begin errors++; $display("FAIL btb_flags: got %b%b expected 11", out_pred_taken, out_next_pc_predicted); end
        checks++; if (out_predicted_next_pc !== 32'h40) begin errors++; $display("FAIL btb_pnpc: got %h expected 40", out_predicted_next_pc); end
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL btb_next_pc: got %h expected 40", pc); end
        idle();
        inst_is_branch = 1; predict_taken = 0; btb_hit = 1; btb_target = 32'h80;
        #1;
        checks++; if ({out_pred_taken, out_next_pc_predicted, out_predicted_next_pc} !== 34'd0) begin errors++; $display("FAIL nt_branch_outs: got %b %b %h expected zero", out_pred_taken, out_next_pc_predicted, out_predicted_next_pc); end
        tick();
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL nt_branch_pc: got %h expected 44", pc); end
    endtask

    task automatic test_btb_miss();
        redirect(32'h20);
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL miss_setup_pc: got %h expected 20", pc); end
        inst_is_branch = 1; predict_taken = 1; btb_hit = 0; btb_target = 32'h999;
        #1;
        checks++; if ({pipe_op, out_pred_taken, out_next_pc_predicted} !== 4'b0010) begin errors++; $display("FAIL miss_outs: got op=%0d pt=%b npp=%b expected op=0 pt=1 npp=0", pipe_op, out_pred_taken, out_next_pc_predicted); end
        checks++; if (out_predicted_next_pc !== 32'h0) begin errors++; $display("FAIL miss_pnpc: got %h expected 0", out_predicted_next_pc); end
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++; if ({state, pipe_op} !== 3'b110) begin errors++; $display("FAIL wait%0d: got state=%b op=%0d expected state=1 op=2", i, state, pipe_op); end
            checks++; if (pc !== 32'h20) begin errors++; $display("FAIL wait_pc%0d: got %h expected 20", i, pc); end
            tick();
        end
        resolve_valid = 1; resolve_pc = 32'h80;
        #1;
        checks++; if (pipe_op !== 2'd2) begin errors++; $display("FAIL resolve_op: got %0d expected 2", pipe_op); end
        tick();
        checks++; if ({pc, state} !== {32'h80, 1'b0}) begin errors++; $display("FAIL resolve_pc: got %h state %b expected 80 state 0", pc, state); end
        resolve_pc = 32'h300;
        #1;
        checks++; if (pipe_op !== 2'd0) begin errors++; $display("FAIL resolve_in_run_op: got %0d expected 0", pipe_op); end
        tick();
        checks++; if (pc !== 32'h84) begin errors++; $display("FAIL resolve_in_run_pc: got %h expected 84", pc); end
    endtask

    task automatic test_stall();
        redirect(32'h8);
        data_hazard = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({pipe_op, pc} !== {2'd1, 32'h8}) begin errors++; $display("FAIL hold%0d: got op=%0d pc=%h expected op=1 pc=8", i, pipe_op, pc); end
            tick();
        end
        checks++; if (stall_cycles !== 16'd5) begin errors++; $display("FAIL stall_count: got %0d expected 5", stall_cycles); end
        data_hazard = 0; structure_stall = 1; mispredict = 1; redirect_pc = 32'h103;
        #1;
        checks++; if (pipe_op !== 2'd2) begin errors++; $display("FAIL mp_over_stall_op: got %0d expected 2", pipe_op); end
        tick();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mp_over_stall_pc: got %h expected 100", pc); end
        checks++; if (stall_cycles !== 16'd5) begin errors++; $display("FAIL mp_stall_count: got %0d expected 5", stall_cycles); end
    endtask

    task automatic test_mispredict_in_wait();
        idle();
        inst_is_branch = 1; predict_taken = 1;
        tick();
        idle();
        checks++; if (state !== 1'b1) begin errors++; $display("FAIL mpw_enter: got %b expected 1", state); end
        mispredict = 1; redirect_pc = 32'h200; resolve_valid = 1; resolve_pc = 32'h300;
        tick();
        checks++; if ({pc, state} !== {32'h200, 1'b0}) begin errors++; $display("FAIL mpw_pc: got %h state %b expected 200 state 0", pc, state); end
    endtask

    task automatic test_timeout();
        idle();
        inst_is_branch = 1; predict_taken = 1;
        tick();
        idle();
        for (int i = 0; i < 30; i++) tick();
        data_hazard = 1;
        tick();
        tick();
        data_hazard = 0;
        for (int i = 0; i < 33; i++) tick();
        checks++; if (wait_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", wait_timeout); end
        checks++; if (stall_cycles !== 16'd7) begin errors++; $display("FAIL timeout_stall_count: got %0d expected 7", stall_cycles); end
        tick();
        checks++; if (wait_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b expected 1", wait_timeout); end
        resolve_valid = 1; resolve_pc = 32'h401;
        tick();
        idle();
        tick();
        tick();
        checks++; if ({pc, state, wait_timeout} !== {32'h408, 1'b0, 1'b1}) begin errors++; $display("FAIL timeout_sticky: got pc=%h state=%b wto=%b expected 408 0 1", pc, state, wait_timeout); end
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++; if ({pc, wait_timeout, stall_cycles} !== 49'd0) begin errors++; $display("FAIL timeout_clear: got pc=%h wto=%b stall=%0d expected zeros", pc, wait_timeout, stall_cycles); end
    endtask

    task automatic test_wrap();
        redirect(32'hFFFF_FFFF);
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h expected fffffffc", pc); end
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", pc); end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_btb_hit();
        test_btb_miss();
        test_stall();
        test_mispredict_in_wait();
        test_timeout();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the fetch PC register and decides, every cycle, what the fetch pipeline register does: advance, hold or bubble.
- Arbitrates among branch-mispredict redirect, data-hazard/structure stalls, BTB-predicted jumps and waiting for a resolved target after a predicted-taken BTB miss.
- Sits between the controller/execute redirect path and the instruction-memory/decode pipe register.

Parameters:
- PC_WIDTH, 32, width of the PC and of all target ports.
- RESET_PC, 0, PC value loaded on reset.
- WAIT_TIMEOUT, 64, WAIT_TARGET cycles (excluding stall cycles) at which wait_timeout is raised.
- CNT_WIDTH, 16, width of the stall_cycles counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- inst_is_branch  in  1  fetched instruction has opcode bit 6 set.
- predict_taken  in  1  branch predictor says taken.
- btb_hit  in  1  BTB holds a target for the current pc.
- btb_target  in  PC_WIDTH  BTB predicted target.
- data_hazard  in  1  decode true-dependence stall.
- structure_stall  in  1  structural stall.
- mispredict  in  1  execute reports misprediction.
- redirect_pc  in  PC_WIDTH  correct PC on mispredict.
- resolve_valid  in  1  execute delivers the target of the waiting branch.
- resolve_pc  in  PC_WIDTH  that target.
- pc  out  PC_WIDTH  current fetch PC (registered).
- pipe_op  out  2  action for the decode pipe register at the next edge: 0 ADVANCE, 1 HOLD, 2 BUBBLE (combinational).
- out_pred_taken  out  1  value to latch into isBranchTakenPredicted on ADVANCE.
- out_next_pc_predicted  out  1  value to latch into isNextPcPredicted on ADVANCE.
- out_predicted_next_pc  out  PC_WIDTH  value to latch into predictedNextPC.
- state  out  1  0 RUN, 1 WAIT_TARGET (registered).
- stall_cycles  out  CNT_WIDTH  count of HOLD cycles, saturating.
- wait_timeout  out  1  sticky error flag.

Behaviour:
- Reset (rst=1 at the edge): pc=RESET_PC, state=RUN, stall_cycles=0, wait counter=0, wait_timeout=0. While rst=1, pipe_op=BUBBLE and out_pred_taken, out_next_pc_predicted and out_predicted_next_pc are all 0.
- pc[1:0] is always 00. Bits [1:0] of every loaded target are forced to 0. pc+4 wraps modulo 2^PC_WIDTH.
- Per-cycle priority, highest first; exactly one case applies:
  1. mispredict: pipe_op=BUBBLE; pc<=redirect_pc; state<=RUN; wait counter cleared. This wins over stalls, WAIT_TARGET and resolve_valid.
  2. data_hazard|structure_stall: pipe_op=HOLD; pc, state and wait counter unchanged; stall_cycles++ (saturates at all-ones).
  3. WAIT_TARGET with resolve_valid: pipe_op=BUBBLE; pc<=resolve_pc; state<=RUN; wait counter<=0.
  4. WAIT_TARGET without resolve_valid: pipe_op=BUBBLE; pc held; wait counter++ (saturating). When the counter reaches WAIT_TIMEOUT, set wait_timeout; it stays set until reset.
  5. RUN, inst_is_branch, predict_taken, btb_hit: pipe_op=ADVANCE; out_pred_taken=1; out_next_pc_predicted=1; out_predicted_next_pc=btb_target; pc<=btb_target.
  6. RUN, inst_is_branch, predict_taken, !btb_hit: pipe_op=ADVANCE; out_pred_taken=1; out_next_pc_predicted=0; pc held; state<=WAIT_TARGET.
  7. RUN, otherwise (non-branch, or branch predicted not-taken): pipe_op=ADVANCE; out_pred_taken=predict_taken&inst_is_branch; out_next_pc_predicted=0; pc<=pc+4.
- out_predicted_next_pc is 0 whenever out_next_pc_predicted=0.
- resolve_valid is ignored in RUN.
- Latency: a redirect or resolve seen at edge N puts the new pc on the output after edge N. The first instruction from that pc is ADVANCEd at edge N+1.

Test Plan:
- Reset with rst=1 for 2 cycles, then straight-line non-branches -> pc 0,4,8,12; pipe_op=ADVANCE each cycle; stall_cycles=0.
- At pc=0x10, taken branch with btb_hit and btb_target=0x40 -> ADVANCE, out_next_pc_predicted=1, out_predicted_next_pc=0x40; next pc=0x40.
- At pc=0x20, taken branch with btb miss -> state=WAIT_TARGET and BUBBLE for 3 cycles; resolve_valid with resolve_pc=0x80 -> pc=0x80, state=RUN.
- data_hazard held 5 cycles at pc=0x8 -> HOLD, pc stays 0x8, stall_cycles=5. Then mispredict with structure_stall=1 and redirect_pc=0x103 -> BUBBLE, pc=0x100.
- In WAIT_TARGET, mispredict and resolve_valid asserted together (redirect_pc=0x200, resolve_pc=0x300) -> pc=0x200.
- WAIT_TARGET for 64 cycles with no resolve -> wait_timeout=1 and stays 1 after returning to RUN; clears only on rst.
